// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular IF->ID instruction buffer.
// Each entry holds {instruction, PC, PC+4, predicted-taken}. Valid/ready on both
// sides, first-word fall-through on the output, FLUSH empties the queue on a redirect.
module fetch_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         FLUSH,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [INSTR_W-1:0]           Instr1_IF,
  input  logic [ADDR_W-1:0]            Instr_PC_IF,
  input  logic [ADDR_W-1:0]            Instr_PC_Plus4_IF,
  input  logic                         Pred_Taken_IF,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [INSTR_W-1:0]           Instr1_OUT,
  output logic [ADDR_W-1:0]            Instr_PC_OUT,
  output logic [ADDR_W-1:0]            Instr_PC_Plus4_OUT,
  output logic                         Pred_Taken_OUT,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Entry storage, one register set per slot.
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [ADDR_W-1:0]  pc4_q   [DEPTH];
  logic               pt_q    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Handshake status; full blocks pushes even when a pop happens this cycle.
  assign IN_READY  = (count_q != CW'(DEPTH));
  assign OUT_VALID = (count_q != '0);
  assign push      = IN_VALID & IN_READY & ~FLUSH;
  assign pop       = OUT_VALID & OUT_READY & ~FLUSH;
  assign COUNT     = count_q;

  // Head entry drives the outputs directly; forced to zero while empty.
  always_comb begin
    Instr1_OUT         = '0;
    Instr_PC_OUT       = '0;
    Instr_PC_Plus4_OUT = '0;
    Pred_Taken_OUT     = 1'b0;
    if (OUT_VALID) begin
      Instr1_OUT         = instr_q[rd_ptr_q];
      Instr_PC_OUT       = pc_q[rd_ptr_q];
      Instr_PC_Plus4_OUT = pc4_q[rd_ptr_q];
      Pred_Taken_OUT     = pt_q[rd_ptr_q];
    end
  end

  // Next-state for pointers and occupancy; FLUSH overrides any same-cycle transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Per-slot write: a slot captures the incoming entry when it is the write target.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        instr_q[gi] <= '0;
        pc_q[gi]    <= '0;
        pc4_q[gi]   <= '0;
        pt_q[gi]    <= 1'b0;
      end else if (push && (wr_ptr_q == PW'(gi))) begin
        instr_q[gi] <= Instr1_IF;
        pc_q[gi]    <= Instr_PC_IF;
        pc4_q[gi]   <= Instr_PC_Plus4_IF;
        pt_q[gi]    <= Pred_Taken_IF;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: the stimulus process pushes the
// expected entry on every accepted push; the monitor pops and compares each
// time the DUT presents a head entry that is consumed.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pt;
  } entry_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          FLUSH = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [31:0]   Instr1_IF = '0;
  logic [31:0]   Instr_PC_IF = '0;
  logic [31:0]   Instr_PC_Plus4_IF = '0;
  logic          Pred_Taken_IF = 1'b0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [31:0]   Instr1_OUT;
  logic [31:0]   Instr_PC_OUT;
  logic [31:0]   Instr_PC_Plus4_OUT;
  logic          Pred_Taken_OUT;
  logic [CW-1:0] COUNT;

  int checks = 0;
  int errors = 0;
  int model_count = 0;
  bit mon_en = 1'b0;
  entry_t sb[$];

  fetch_decode_queue #(.DEPTH(DEPTH), .INSTR_W(32), .ADDR_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .Instr1_IF(Instr1_IF), .Instr_PC_IF(Instr_PC_IF),
    .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF), .Pred_Taken_IF(Pred_Taken_IF),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT),
    .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT), .Pred_Taken_OUT(Pred_Taken_OUT),
    .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the scoreboard and occupancy model follow the
  // acceptance rules (full rejects, empty never pops, FLUSH drops both).
  task automatic cycle(input bit in_v, input logic [31:0] pc, input bit pt,
                       input bit out_r, input bit fl);
    bit acc, popd;
    IN_VALID          = in_v;
    Instr_PC_IF       = pc;
    Instr_PC_Plus4_IF = pc + 32'd4;
    Instr1_IF         = mk_instr(pc);
    Pred_Taken_IF     = pt;
    OUT_READY         = out_r;
    FLUSH             = fl;
    acc  = in_v && (model_count != DEPTH) && !fl;
    popd = out_r && (model_count != 0) && !fl;
    if (acc) sb.push_back('{mk_instr(pc), pc, pc + 32'd4, pt});
    @(posedge CLK);
    #1;
    if (fl) begin
      model_count = 0;
      sb.delete();
    end else begin
      if (acc && !popd) model_count++;
      else if (popd && !acc) model_count--;
    end
    $display("cycle t=%0t in_v=%0b pc=0x%0h out_r=%0b flush=%0b -> COUNT=%0d", $time, in_v, pc, out_r, fl, COUNT);
    chk("count_model", 64'(COUNT), 64'(model_count));
    chk("in_ready_model", 64'(IN_READY), 64'(model_count != DEPTH));
    chk("out_valid_model", 64'(OUT_VALID), 64'(model_count != 0));
    IN_VALID  = 1'b0;
    FLUSH     = 1'b0;
  endtask

  // Monitor: compare the head entry whenever it is consumed; empty outputs must be zero.
  always @(negedge CLK) begin
    entry_t e;
    if (mon_en && !RESET) begin
      if (OUT_VALID && OUT_READY && !FLUSH) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc 0x%0h expected no entry", Instr_PC_OUT);
        end else begin
          e = sb.pop_front();
          $display("pop pc=0x%0h pc4=0x%0h pt=%0b instr=0x%0h", Instr_PC_OUT, Instr_PC_Plus4_OUT, Pred_Taken_OUT, Instr1_OUT);
          chk("head_instr", 64'(Instr1_OUT), 64'(e.instr));
          chk("head_pc", 64'(Instr_PC_OUT), 64'(e.pc));
          chk("head_pc4", 64'(Instr_PC_Plus4_OUT), 64'(e.pc4));
          chk("head_pt", 64'(Pred_Taken_OUT), 64'(e.pt));
        end
      end else if (!OUT_VALID) begin
        chk("empty_outputs_zero", {Instr1_OUT, Instr_PC_OUT} | 64'(Instr_PC_Plus4_OUT) | 64'(Pred_Taken_OUT), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_count", 64'(COUNT), 64'd0);
    chk("reset_in_ready", 64'(IN_READY), 64'd1);
    chk("reset_out_valid", 64'(OUT_VALID), 64'd0);
    RESET = 1'b0;
    mon_en = 1'b1;

    // 1: asynchronous reset mid-stream
    cycle(1, 32'h10, 0, 0, 0);
    cycle(1, 32'h14, 1, 0, 0);
    chk("t1_count_before", 64'(COUNT), 64'd2);
    #3 RESET = 1'b1;
    #1;
    chk("t1_async_count", 64'(COUNT), 64'd0);
    chk("t1_async_out_valid", 64'(OUT_VALID), 64'd0);
    chk("t1_async_in_ready", 64'(IN_READY), 64'd1);
    chk("t1_async_pc", 64'(Instr_PC_OUT), 64'd0);
    chk("t1_async_instr", 64'(Instr1_OUT), 64'd0);
    model_count = 0;
    sb.delete();
    @(posedge CLK);
    #1 RESET = 1'b0;

    // 2: fill to full, rejected fifth push, drain in order
    for (int k = 0; k < 4; k++) cycle(1, 32'h100 + 32'(4*k), k[0], 0, 0);
    chk("t2_full_count", 64'(COUNT), 64'd4);
    chk("t2_full_in_ready", 64'(IN_READY), 64'd0);
    cycle(1, 32'h110, 0, 0, 0);
    chk("t2_reject_count", 64'(COUNT), 64'd4);
    chk("t2_head_stable", 64'(Instr_PC_OUT), 64'h100);
    for (int k = 0; k < 4; k++) cycle(0, 32'h0, 0, 1, 0);
    chk("t2_drained", 64'(COUNT), 64'd0);

    // 3: steady push&pop at COUNT=2, pointers wrap
    cycle(1, 32'h1F8, 0, 0, 0);
    cycle(1, 32'h1FC, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(1, 32'h200 + 32'(4*k), k[1], 1, 0);
      chk("t3_count_steady", 64'(COUNT), 64'd2);
    end
    chk("t3_head_after", 64'(Instr_PC_OUT), 64'h220);
    cycle(0, 32'h0, 0, 1, 0);
    cycle(0, 32'h0, 0, 1, 0);
    chk("t3_drained", 64'(COUNT), 64'd0);

    // 4: full with pop and push in the same cycle: no push-through
    for (int k = 0; k < 4; k++) cycle(1, 32'h300 + 32'(4*k), 0, 0, 0);
    cycle(1, 32'h310, 1, 1, 0);
    chk("t4_count", 64'(COUNT), 64'd3);
    chk("t4_head", 64'(Instr_PC_OUT), 64'h304);

    // 5: FLUSH wins over same-cycle push and pop
    cycle(1, 32'h314, 0, 1, 1);
    chk("t5_flush_count", 64'(COUNT), 64'd0);
    chk("t5_flush_out_valid", 64'(OUT_VALID), 64'd0);
    chk("t5_flush_in_ready", 64'(IN_READY), 64'd1);
    cycle(1, 32'h400, 1, 0, 0);
    chk("t5_head_pc", 64'(Instr_PC_OUT), 64'h400);
    chk("t5_head_pt", 64'(Pred_Taken_OUT), 64'd1);
    cycle(0, 32'h0, 0, 1, 0);

    // 6: single entry fall-through then pop
    cycle(1, 32'h500, 1, 1, 0);
    chk("t6_out_valid", 64'(OUT_VALID), 64'd1);
    chk("t6_pc", 64'(Instr_PC_OUT), 64'h500);
    chk("t6_pt", 64'(Pred_Taken_OUT), 64'd1);
    cycle(0, 32'h0, 0, 1, 0);
    chk("t6_count", 64'(COUNT), 64'd0);

    repeat (2) @(posedge CLK);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
